vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Downstream stage of the 640x480 VGA timing generator; consumes its h/v pixel counters and sync/blank signals and produces registered RGB plus delay-matched syncs for the VGA PMOD.
- Selects one of four test patterns: colour bars, checkerboard, bouncing box, frame-ramped grey.
- Pattern state advances on a user pulse or automatically.
- Runs entirely in the PLL pixel-clock domain.

Parameters:
- H_DISPLAY, 640, active pixels per line
- V_DISPLAY, 480, active lines per frame
- COLOR_W, 4, bits per colour channel
- BOX_SIZE, 32, bouncing box edge length in pixels
- FRAMES_PER_PATTERN, 120, frames before auto-advance (used only with VGA_PAT_AUTO_EN)

Ports:
- clk_in  in  1  pixel clock (PLL sys_clk, 25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- h_count  in  10  horizontal pixel counter, 0..799
- v_count  in  10  vertical line counter, 0..524
- hsync_in  in  1  horizontal sync from timing generator, active low
- vsync_in  in  1  vertical sync from timing generator, active low
- de_in  in  1  active-video flag (h_count<H_DISPLAY and v_count<V_DISPLAY)
- next_pat  in  1  single-cycle request to advance pattern, synchronous
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- hsync  out  1  delayed hsync
- vsync  out  1  delayed vsync
- pattern_id  out  2  currently displayed pattern

Behaviour:
- Clocking and reset: one clock, clk_in. Reset is asynchronous and active-low on rst_n.
- Reset values: red/green/blue=0; hsync=1; vsync=1; pattern_id=0 (BARS); box at (0,0) moving +x,+y; frame counter=0; pending request=0. Reset takes effect immediately mid-frame; the first frame after release starts with BARS.
- Pipeline latency is exactly 2 clocks from inputs to all outputs.
  - Stage 1 registers counters, de, syncs and colour-select decode.
  - Stage 2 registers final RGB and syncs.
  - hsync, vsync and RGB stay aligned.
- Blanking: when delayed de=0, RGB=0 regardless of pattern.
- Frame tick: a one-cycle pulse when h_count==0 and v_count==V_DISPLAY, i.e. at the start of vertical blanking. All pattern, box and frame-counter updates happen only on the frame tick, never during active video.
- Pattern FSM: BARS(0) -> CHECKER(1) -> BOX(2) -> GREY(3) -> BARS.
  - A next_pat pulse sets a pending flag.
  - On a frame tick with pending=1, advance one state and clear pending.
  - Multiple pulses within one frame produce only one advance.
  - A pulse arriving in the same cycle as the frame tick advances on that tick.
- BARS: 8 vertical bars, each H_DISPLAY/8=80 px wide. Bar index comes from comparator thresholds (no divider). Colours left to right: white, yellow, cyan, green, magenta, red, blue, black. Full-scale channels = all ones.
- CHECKER: white when h_count[5]^v_count[5]=1, else black. Squares are 32x32.
- BOX: white box BOX_SIZE square at (bx,by) on a blue background. Pixel is in the box when bx<=h<bx+BOX_SIZE and by<=v<by+BOX_SIZE.
  - Each frame tick moves the box 1 px in x and 1 px in y.
  - x direction reverses when bx reaches H_DISPLAY-BOX_SIZE (608) or 0. y direction reverses at V_DISPLAY-BOX_SIZE (448) or 0.
  - On a reversal tick the position holds at the limit (no overshoot).
  - The box moves in all patterns, not only BOX.
- GREY: all channels = frame_cnt[7:8-COLOR_W]. frame_cnt is an 8-bit counter incremented each frame tick; it wraps 255->0.

Optional Feature:
- Macro: VGA_PAT_AUTO_EN.
- Defined: a frame-count-down counter triggers an advance after FRAMES_PER_PATTERN frame ticks in the current pattern, then reloads. A next_pat advance also reloads the counter. A simultaneous auto and manual advance moves only one step.
- Undefined: the counter logic is absent and only next_pat advances the pattern.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480 timing constants (totals, porches, sync start/width)
  - pattern enum typedef (BARS, CHECKER, BOX, GREY)
  - 3-bit bar colour index type
- Sub-module vga_box_mover: box position/direction registers, bounce logic and frame-tick update. Outputs bx[9:0] and by[9:0].

Test Plan:
- Reset and latency: assert rst_n=0 mid-line -> RGB=0, hsync=vsync=1 immediately. After release, hsync_in falling at cycle T -> hsync falls at T+2.
- Bars: pattern 0, v=100, h=0/80/160/639 -> RGB (F,F,F)/(F,F,0)/(0,F,F)/(0,0,0) at 2 clocks later. h=700 (de=0) -> (0,0,0).
- Advance: pulse next_pat 3 times at v=200 -> pattern_id stays 0 until the frame tick at v=480,h=0, then becomes 1 (single advance).
- Box bounce: run 608 frames from reset -> bx=608. Next frame -> bx=607. Frame 448 -> by=448. Pixel (608,448) is white in BOX pattern.
- Checker: pattern 1, (h,v)=(31,0) -> white? No: h[5]^v[5]=0 -> black. (32,0) -> white. (32,32) -> black.
- Auto (VGA_PAT_AUTO_EN, FRAMES_PER_PATTERN=2): no next_pat -> pattern_id 0,0,1,1,2,2,3,3,0 across ticks. A next_pat coinciding with an auto tick -> +1 only.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared 640x480 VGA constants, pattern enum and bar colour helpers.
// Imported by vga_pattern_gen and vga_box_mover.
package vga_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC_WIDTH = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;

  localparam int V_ACTIVE     = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC_WIDTH = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;

  typedef enum logic [1:0] {
    BARS    = 2'd0,
    CHECKER = 2'd1,
    BOX     = 2'd2,
    GREY    = 2'd3
  } pattern_t;

  typedef logic [2:0] bar_idx_t;

  // Returns {r,g,b} on/off bits for each bar, white on the left to black on the right.
  function automatic logic [2:0] bar_rgb(input bar_idx_t idx);
    case (idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

  function automatic pattern_t next_pattern(input pattern_t p);
    next_pattern = pattern_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing box position: moves 1 px diagonally per frame tick and reverses
// direction on the tick that lands on an edge, so it never overshoots.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int H_LIMIT = 608,
  parameter int V_LIMIT = 448
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       frame_tick,
  output logic [9:0] bx,
  output logic [9:0] by
);

  localparam logic [9:0] H_LIM = 10'(H_LIMIT);
  localparam logic [9:0] V_LIM = 10'(V_LIMIT);

  logic       x_fwd, y_fwd;
  logic [9:0] bx_next, by_next;

  assign bx_next = x_fwd ? bx + 10'd1 : bx - 10'd1;
  assign by_next = y_fwd ? by + 10'd1 : by - 10'd1;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bx    <= '0;
      by    <= '0;
      x_fwd <= 1'b1;
      y_fwd <= 1'b1;
    end else if (frame_tick) begin
      bx <= bx_next;
      by <= by_next;
      if (x_fwd && bx_next == H_LIM)      x_fwd <= 1'b0;
      else if (!x_fwd && bx_next == '0)   x_fwd <= 1'b1;
      if (y_fwd && by_next == V_LIM)      y_fwd <= 1'b0;
      else if (!y_fwd && by_next == '0)   y_fwd <= 1'b1;
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern generator (bars, checker, bouncing box, grey ramp).
// Define VGA_PAT_AUTO_EN to auto-advance the pattern every FRAMES_PER_PATTERN frames.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY          = 640,
  parameter int V_DISPLAY          = 480,
  parameter int COLOR_W            = 4,
  parameter int BOX_SIZE           = 32,
  parameter int FRAMES_PER_PATTERN = 120
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [9:0]         h_count,
  input  logic [9:0]         v_count,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               de_in,
  input  logic               next_pat,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               hsync,
  output logic               vsync,
  output logic [1:0]         pattern_id
);

  localparam int BAR_W = H_DISPLAY / 8;

  logic               frame_tick;
  pattern_t           pat_q, pat_d;
  logic               pend_q, pend_d, advance, auto_hit;
  logic [7:0]         frame_cnt;
  logic [9:0]         bx, by;
  logic               in_box;
  bar_idx_t           bar_idx;
  logic [2:0]         bar_bits;
  logic [COLOR_W-1:0] col_r, col_g, col_b;
  logic [COLOR_W-1:0] r_d1, g_d1, b_d1;
  logic               de_d1, hs_d1, vs_d1;

  assign frame_tick = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
  assign pattern_id = pat_q;

`ifdef VGA_PAT_AUTO_EN
  localparam int CNT_W = $clog2(FRAMES_PER_PATTERN + 1);
  logic [CNT_W-1:0] auto_cnt;

  assign auto_hit = (auto_cnt == CNT_W'(1));

  // Any advance, manual or automatic, gives the new pattern a full dwell time.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)               auto_cnt <= CNT_W'(FRAMES_PER_PATTERN);
    else if (frame_tick) begin
      if (advance)            auto_cnt <= CNT_W'(FRAMES_PER_PATTERN);
      else                    auto_cnt <= auto_cnt - 1'b1;
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= BARS;
      pend_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      pend_q <= pend_d;
    end
  end

  // Requests are latched until the next frame tick so changes land in blanking.
  always_comb begin
    pat_d   = pat_q;
    pend_d  = pend_q;
    advance = 1'b0;
    if (frame_tick) begin
      advance = pend_q | next_pat | auto_hit;
      pend_d  = 1'b0;
    end else if (next_pat) begin
      pend_d = 1'b1;
    end
    if (advance) pat_d = next_pattern(pat_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)          frame_cnt <= '0;
    else if (frame_tick) frame_cnt <= frame_cnt + 8'd1;
  end

  vga_box_mover #(
    .H_LIMIT (H_DISPLAY - BOX_SIZE),
    .V_LIMIT (V_DISPLAY - BOX_SIZE)
  ) u_box (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .bx         (bx),
    .by         (by)
  );

  assign in_box = ({1'b0, h_count} >= {1'b0, bx}) &&
                  ({1'b0, h_count} <  {1'b0, bx} + 11'(BOX_SIZE)) &&
                  ({1'b0, v_count} >= {1'b0, by}) &&
                  ({1'b0, v_count} <  {1'b0, by} + 11'(BOX_SIZE));

  // Bar index from a descending comparator chain rather than a divide.
  always_comb begin
    bar_idx = 3'd7;
    for (int i = 7; i >= 1; i--) begin
      if (h_count < 10'(i * BAR_W)) bar_idx = bar_idx_t'(i - 1);
    end
    bar_bits = bar_rgb(bar_idx);
    col_r    = '0;
    col_g    = '0;
    col_b    = '0;
    case (pat_q)
      BARS: begin
        col_r = {COLOR_W{bar_bits[2]}};
        col_g = {COLOR_W{bar_bits[1]}};
        col_b = {COLOR_W{bar_bits[0]}};
      end
      CHECKER: begin
        col_r = {COLOR_W{h_count[5] ^ v_count[5]}};
        col_g = {COLOR_W{h_count[5] ^ v_count[5]}};
        col_b = {COLOR_W{h_count[5] ^ v_count[5]}};
      end
      BOX: begin
        col_r = {COLOR_W{in_box}};
        col_g = {COLOR_W{in_box}};
        col_b = '1;
      end
      GREY: begin
        col_r = frame_cnt[7 -: COLOR_W];
        col_g = frame_cnt[7 -: COLOR_W];
        col_b = frame_cnt[7 -: COLOR_W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_d1  <= '0;
      g_d1  <= '0;
      b_d1  <= '0;
      de_d1 <= 1'b0;
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
    end else begin
      r_d1  <= col_r;
      g_d1  <= col_g;
      b_d1  <= col_b;
      de_d1 <= de_in;
      hs_d1 <= hsync_in;
      vs_d1 <= vsync_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      red   <= de_d1 ? r_d1 : '0;
      green <= de_d1 ? g_d1 : '0;
      blue  <= de_d1 ? b_d1 : '0;
      hsync <= hs_d1;
      vsync <= vs_d1;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: reset, latency, bars, advance, checker,
// box bounce and grey ramp; auto-advance sequence when VGA_PAT_AUTO_EN is set.
module tb_vga_pattern_gen;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [9:0] h_count, v_count;
  logic       hsync_in, vsync_in, de_in, next_pat;
  logic [3:0] red, green, blue;
  logic       hsync, vsync;
  logic [1:0] pattern_id;

  int check_count = 0;
  int error_count = 0;

  vga_pattern_gen #(.FRAMES_PER_PATTERN(2)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .h_count    (h_count),
    .v_count    (v_count),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .de_in      (de_in),
    .next_pat   (next_pat),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hsync      (hsync),
    .vsync      (vsync),
    .pattern_id (pattern_id)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [11:0] got, input logic [11:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one pixel and wait until it emerges from the two-stage pipeline.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input logic de);
    h_count = h;
    v_count = v;
    de_in   = de;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkPixel(input string tag, input logic [9:0] h, input logic [9:0] v,
                            input logic [11:0] exp);
    applyStimulus(h, v, 1'b1);
    checkOutput(tag, {red, green, blue}, exp);
  endtask

  task automatic frameTick(input logic pulse);
    h_count  = 10'd0;
    v_count  = 10'd480;
    de_in    = 1'b0;
    next_pat = pulse;
    @(posedge clk_in);
    #1;
    next_pat = 1'b0;
    h_count  = 10'd1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) frameTick(1'b0);
  endtask

  task automatic settle();
    @(posedge clk_in);
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    h_count  = 10'd0;
    v_count  = 10'd0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    next_pat = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("reset_rgb", {red, green, blue}, 12'h000);
    checkOutput("reset_sync", {10'd0, hsync, vsync}, 12'h003);
    checkOutput("reset_pat", {10'd0, pattern_id}, 12'h000);
    rst_n = 1'b1;

`ifdef VGA_PAT_AUTO_EN
    begin
      logic [1:0] auto_exp [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
      for (int k = 0; k < 8; k++) begin
        frameTick(1'b0);
        settle();
        checkOutput($sformatf("auto_tick%0d", k + 1), {10'd0, pattern_id}, {10'd0, auto_exp[k]});
      end
      frameTick(1'b1);
      settle();
      checkOutput("auto_manual", {10'd0, pattern_id}, 12'h001);
      frameTick(1'b0);
      settle();
      checkOutput("auto_reload", {10'd0, pattern_id}, 12'h001);
      frameTick(1'b1);
      settle();
      checkOutput("auto_coincide", {10'd0, pattern_id}, 12'h002);
      frameTick(1'b0);
      settle();
      checkOutput("auto_after", {10'd0, pattern_id}, 12'h002);
    end
`else
    // Reset mid-line clears outputs without waiting for a clock edge.
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    applyStimulus(10'd0, 10'd100, 1'b1);
    checkOutput("pre_reset_rgb", {red, green, blue}, 12'hFFF);
    checkOutput("pre_reset_sync", {10'd0, hsync, vsync}, 12'h000);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rgb", {red, green, blue}, 12'h000);
    checkOutput("async_sync", {10'd0, hsync, vsync}, 12'h003);
    @(posedge clk_in);
    #1;
    rst_n    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;

    hsync_in = 1'b0;
    @(posedge clk_in);
    #1;
    checkOutput("hsync_lat1", {11'd0, hsync}, 12'h001);
    @(posedge clk_in);
    #1;
    checkOutput("hsync_lat2", {11'd0, hsync}, 12'h000);
    hsync_in = 1'b1;

    begin
      logic [9:0]  bar_h   [10] = '{10'd0, 10'd79, 10'd80, 10'd160, 10'd240,
                                    10'd320, 10'd400, 10'd480, 10'd560, 10'd639};
      logic [11:0] bar_exp [10] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                    12'hF0F, 12'hF00, 12'h00F, 12'h000, 12'h000};
      for (int k = 0; k < 10; k++)
        checkPixel($sformatf("bars_h%0d", bar_h[k]), bar_h[k], 10'd100, bar_exp[k]);
    end
    applyStimulus(10'd700, 10'd100, 1'b0);
    checkOutput("bars_blank", {red, green, blue}, 12'h000);

    for (int k = 0; k < 3; k++) begin
      h_count  = 10'(10 * (k + 1));
      v_count  = 10'd200;
      next_pat = 1'b1;
      @(posedge clk_in);
      #1;
      next_pat = 1'b0;
      @(posedge clk_in);
      #1;
    end
    settle();
    checkOutput("pat_before_tick", {10'd0, pattern_id}, 12'h000);
    frameTick(1'b0);
    settle();
    checkOutput("pat_after_tick1", {10'd0, pattern_id}, 12'h001);
    frameTick(1'b0);
    settle();
    checkOutput("pat_after_tick2", {10'd0, pattern_id}, 12'h001);

    checkPixel("chk_31_0", 10'd31, 10'd0, 12'h000);
    checkPixel("chk_32_0", 10'd32, 10'd0, 12'hFFF);
    checkPixel("chk_32_32", 10'd32, 10'd32, 12'h000);
    checkPixel("chk_0_32", 10'd0, 10'd32, 12'hFFF);

    frameTick(1'b1);
    settle();
    checkOutput("pat_same_cycle", {10'd0, pattern_id}, 12'h002);

    checkPixel("box3_in", 10'd3, 10'd3, 12'hFFF);
    checkPixel("box3_left", 10'd2, 10'd3, 12'h00F);
    checkPixel("box3_far", 10'd34, 10'd34, 12'hFFF);
    checkPixel("box3_right", 10'd35, 10'd34, 12'h00F);
    applyStimulus(10'd3, 10'd3, 1'b0);
    checkOutput("box_blank", {red, green, blue}, 12'h000);

    runTicks(445);
    checkPixel("box448_in", 10'd448, 10'd448, 12'hFFF);
    checkPixel("box448_left", 10'd447, 10'd448, 12'h00F);
    checkPixel("box448_above", 10'd448, 10'd447, 12'h00F);
    checkPixel("box448_corner", 10'd479, 10'd479, 12'hFFF);
    checkPixel("box448_right", 10'd480, 10'd448, 12'h00F);

    runTicks(160);
    checkPixel("box608_in", 10'd608, 10'd288, 12'hFFF);
    checkPixel("box608_left", 10'd607, 10'd288, 12'h00F);
    checkPixel("box608_corner", 10'd639, 10'd319, 12'hFFF);
    checkPixel("box608_below", 10'd639, 10'd320, 12'h00F);

    runTicks(1);
    checkPixel("box609_in", 10'd607, 10'd287, 12'hFFF);
    checkPixel("box609_edge", 10'd638, 10'd287, 12'hFFF);
    checkPixel("box609_right", 10'd639, 10'd287, 12'h00F);

    frameTick(1'b1);
    settle();
    checkOutput("pat_grey", {10'd0, pattern_id}, 12'h003);
    checkPixel("grey_610", 10'd100, 10'd100, 12'h666);
    runTicks(30);
    checkPixel("grey_640", 10'd100, 10'd100, 12'h888);

    frameTick(1'b1);
    settle();
    checkOutput("pat_wrap", {10'd0, pattern_id}, 12'h000);
    checkPixel("bars_again", 10'd0, 10'd100, 12'hFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
